bridge_tx_uart: RTL and testbench
=================================

// Module: bridge_tx_uart
// PURPOSE
// - Response side of the host link. Takes read data off the end of the core
//   chain, formats it as the ASCII reply "M" + 4 uppercase hex digits + "\r\n",
//   and shifts it out as UART 8N1, LSB first.
// - It is the counterpart of the RX bridge, which decodes "Raaaa\r\n" and
//   "Waaaadddd\r\n". Its input is the last core's data/rw/valid bus.
// PARAMETERS
// - CLOCKS_PER_BAUD  default 868  clk cycles per UART bit; must be >= 2
// PORTS
// - clk        in   1   system clock; all logic on rising edge
// - rst_n      in   1   synchronous, active-low reset
// - data_i     in   16  read data from the core chain
// - rw_i       in   1   1 = write (no reply), 0 = read (reply)
// - valid_i    in   1   bus qualifier, single-cycle strobe
// - tx         out  1   UART serial output, idle high
// - busy_o     out  1   high while a frame is being sent or a reply is pending
// - overrun_o  out  1   sticky; a read reply was dropped
// BEHAVIOUR
// - Reset values: tx=1, busy_o=0, overrun_o=0. Buffers are empty, FSM=IDLE,
//   baud counter=0.
// - Accept condition: valid_i & ~rw_i. When valid_i & rw_i, nothing happens.
// - Storage is 2 replies deep:
//   - active register: the reply being sent
//   - pending register: 1 entry
// - Accept into active if idle, else into pending if empty. Otherwise drop the
//   reply and set overrun_o=1, which holds until reset.
// - Latency: accept in cycle N (idle) -> tx=0 (start bit of 'M') in cycle N+1.
// - Character sequence, index 0..6:
//   - 0x4D ('M')
//   - hex of data[15:12], [11:8], [7:4], [3:0]
//   - 0x0D, 0x0A
// - Hex mapping: nibble 0-9 -> 0x30+n; nibble A-F -> 0x41+(n-10).
// - Bit FSM states:
//   - IDLE -> START -> DATA(bit 0..7) -> STOP -> next char START, or finish
//   - After the last stop bit: go to IDLE, or load pending into active
//     with no idle gap.
// - Each bit is held exactly CLOCKS_PER_BAUD cycles.
//   - The baud counter runs 0..CLOCKS_PER_BAUD-1 and wraps; the bit advances
//     on the wrap.
// - One character is 10*CLOCKS_PER_BAUD cycles (11 with parity). One reply is
//   7 characters.
// - Timing of busy_o:
//   - rises the cycle after accept
//   - falls in the cycle after the final stop bit completes, if pending is empty
// - Simultaneous events: an accept in the same cycle the active reply finishes
//   goes straight into active. The reply's start bit follows directly after the
//   stop bit. It is not an overrun.
// - The output is registered; tx is glitch-free.
// - Reset mid-frame: tx=1 in the next cycle. Both buffers clear and the partial
//   character is abandoned.
// CONFIGURATION
// - BRIDGE_TX_PARITY_EN defined: an even parity bit (XOR of data bits) is sent
//   between bit 7 and the stop bit. The frame is 11 bits (8E1).
// - Undefined: 8N1 with 10-bit frames, and the PARITY state is absent.
// TESTING
// Common setting: CLOCKS_PER_BAUD=4.
// - Single read, data=0xBEEF:
//   - tx carries 4D 42 45 45 46 0D 0A
//   - each bit lasts 4 clk; whole reply 280 cycles
//   - busy_o high for exactly 280 cycles
// - Write strobe, rw_i=1, data=0x1234: tx stays 1, busy_o stays 0 for
//   500 cycles.
// - Two reads 1 cycle apart (0x0001, 0xA0F9):
//   - "M0001\r\n" then "MA0F9\r\n"
//   - second start bit immediately follows first 0x0A stop bit
//   - overrun_o=0
// - Three reads back-to-back:
//   - first two are sent
//   - third is dropped; overrun_o=1 and stays 1 after the transmit finishes
//   - a later rst_n=0 clears it
// - rst_n=0 during bit 3 of char 2:
//   - tx=1 the next cycle; busy_o=0
//   - a new read after reset starts with a clean 'M'
// - With BRIDGE_TX_PARITY_EN:
//   - 0x0000 -> parity bits: 'M' (0x4D) 0, '0' (0x30) 0, 0x0D 1, 0x0A 0
//   - reply takes 308 cycles

Source files
------------

// File: rtl/bridge_tx_uart.sv
// Host-link reply transmitter: formats read data as "Mxxxx\r\n" and sends it as UART 8N1, LSB first.
// Define BRIDGE_TX_PARITY_EN to add an even parity bit (8E1 framing).
module bridge_tx_uart #(
    parameter int CLOCKS_PER_BAUD = 868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic        rw_i,
    input  logic        valid_i,
    output logic        tx,
    output logic        busy_o,
    output logic        overrun_o
);
    localparam int            BW       = (CLOCKS_PER_BAUD > 1) ? $clog2(CLOCKS_PER_BAUD) : 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLOCKS_PER_BAUD - 1);

`ifdef BRIDGE_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t        state_q;
    logic [BW-1:0] baud_q;
    logic [2:0]    bit_q;
    logic [2:0]    chr_q;
    logic [15:0]   act_q;
    logic [15:0]   pend_q;
    logic          pend_vld_q;
    logic          tx_q;
    logic          busy_q;
    logic          ovr_q;

    logic       accept;
    logic       baud_wrap;
    logic       finish;
    logic [7:0] char_cur;

    function automatic logic [7:0] hex_f(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign accept    = valid_i & ~rw_i;
    assign baud_wrap = (baud_q == BAUD_MAX);
    assign finish    = (state_q == S_STOP) && baud_wrap && (chr_q == 3'd6);

    always_comb begin
        char_cur = 8'h0A;
        case (chr_q)
            3'd0:    char_cur = 8'h4D;
            3'd1:    char_cur = hex_f(act_q[15:12]);
            3'd2:    char_cur = hex_f(act_q[11:8]);
            3'd3:    char_cur = hex_f(act_q[7:4]);
            3'd4:    char_cur = hex_f(act_q[3:0]);
            3'd5:    char_cur = 8'h0D;
            default: char_cur = 8'h0A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            chr_q      <= '0;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            if (state_q != S_IDLE)
                baud_q <= baud_wrap ? '0 : baud_q + BW'(1);

            // Accepts while sending go to pending; the finishing cycle is handled in S_STOP.
            if (accept && state_q != S_IDLE && !finish) begin
                if (!pend_vld_q) begin
                    pend_q     <= data_i;
                    pend_vld_q <= 1'b1;
                end else begin
                    ovr_q <= 1'b1;
                end
            end

            case (state_q)
                S_IDLE: if (accept) begin
                    act_q   <= data_i;
                    chr_q   <= 3'd0;
                    baud_q  <= '0;
                    tx_q    <= 1'b0;
                    busy_q  <= 1'b1;
                    state_q <= S_START;
                end
                S_START: if (baud_wrap) begin
                    bit_q   <= 3'd0;
                    tx_q    <= char_cur[0];
                    state_q <= S_DATA;
                end
                S_DATA: if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
`ifdef BRIDGE_TX_PARITY_EN
                        tx_q    <= ^char_cur;
                        state_q <= S_PARITY;
`else
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
`endif
                    end else begin
                        bit_q <= bit_q + 3'd1;
                        tx_q  <= char_cur[3'(bit_q + 3'd1)];
                    end
                end
`ifdef BRIDGE_TX_PARITY_EN
                S_PARITY: if (baud_wrap) begin
                    tx_q    <= 1'b1;
                    state_q <= S_STOP;
                end
`endif
                S_STOP: if (baud_wrap) begin
                    if (chr_q != 3'd6) begin
                        chr_q   <= chr_q + 3'd1;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                    end else if (pend_vld_q || accept) begin
                        // Back-to-back reply: start bit follows the stop bit with no gap.
                        chr_q   <= 3'd0;
                        tx_q    <= 1'b0;
                        state_q <= S_START;
                        if (pend_vld_q) begin
                            act_q <= pend_q;
                            if (accept) pend_q     <= data_i;
                            else        pend_vld_q <= 1'b0;
                        end else begin
                            act_q <= data_i;
                        end
                    end else begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx        = tx_q;
    assign busy_o    = busy_q;
    assign overrun_o = ovr_q;
endmodule

// File: tb/tb_bridge_tx_uart.sv
// Directed bench for bridge_tx_uart: tx/busy are logged per cycle and compared against hand-computed replies.
module tb_bridge_tx_uart;
    localparam int CPB   = 4;
`ifdef BRIDGE_TX_PARITY_EN
    localparam int FW    = 11;
`else
    localparam int FW    = 10;
`endif
    localparam int CHRL  = FW * CPB;
    localparam int REPLY = 7 * CHRL;
    localparam int LOGN  = 8192;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = '0;
    logic        rw_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        tx, busy_o, overrun_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic tx_log   [LOGN];
    logic busy_log [LOGN];

    typedef struct {
        logic [15:0] data;
        logic        rw;
        logic [55:0] reply;
    } vec_t;
    vec_t tbl[6];

    bridge_tx_uart #(.CLOCKS_PER_BAUD(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .rw_i(rw_i), .valid_i(valid_i),
        .tx(tx), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < LOGN) begin
        tx_log[cyc]   = tx;
        busy_log[cyc] = busy_o;
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Issues one read/write strobe; returns the index of the cycle after accept.
    task automatic strobe(input logic [15:0] d, input logic rw, output int s);
        data_i = d; rw_i = rw; valid_i = 1'b1;
        tick();
        s = cyc;
        valid_i = 1'b0; rw_i = 1'b0;
    endtask

    task automatic check_reply(input int s, input logic [55:0] exp, input string nm);
        logic [7:0]       ch;
        logic [CHRL-1:0]  e, a;
        logic             v;
        for (int c = 0; c < 7; c++) begin
            ch = exp[55-8*c -: 8];
            for (int b = 0; b < FW; b++) begin
                if (b == 0)           v = 1'b0;
                else if (b <= 8)      v = ch[b-1];
                else if (b == FW - 1) v = 1'b1;
                else                  v = ^ch;
                for (int k = 0; k < CPB; k++) begin
                    e[b*CPB+k] = v;
                    a[b*CPB+k] = tx_log[s + c*CHRL + b*CPB + k];
                end
            end
            chk($sformatf("%s char%0d", nm, c), 64'(a), 64'(e));
        end
    endtask

    task automatic check_busy(input int s, input int len, input string nm);
        int n = 0;
        for (int i = 0; i < len; i++) if (busy_log[s+i] === 1'b1) n++;
        chk({nm, " busy_len"}, 64'(n), 64'(len));
        chk({nm, " busy_before"}, 64'(busy_log[s-1]), 64'd0);
        chk({nm, " busy_after"}, 64'(busy_log[s+len]), 64'd0);
    endtask

    task automatic wait_cyc(input int target);
        int guard = 0;
        while (cyc < target && guard < LOGN) begin
            tick();
            guard++;
        end
    endtask

    initial begin
        int s, s2, ones, bz;

        tbl[0] = '{16'hBEEF, 1'b0, 56'h4D_42_45_45_46_0D_0A};
        tbl[1] = '{16'h0000, 1'b0, 56'h4D_30_30_30_30_0D_0A};
        tbl[2] = '{16'h1234, 1'b1, 56'h0};
        tbl[3] = '{16'h09AF, 1'b0, 56'h4D_30_39_41_46_0D_0A};
        tbl[4] = '{16'hFFFF, 1'b0, 56'h4D_46_46_46_46_0D_0A};
        tbl[5] = '{16'h5A6C, 1'b0, 56'h4D_35_41_36_43_0D_0A};

        tick(3);
        chk("reset tx", 64'(tx), 64'd1);
        chk("reset busy", 64'(busy_o), 64'd0);
        chk("reset overrun", 64'(overrun_o), 64'd0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 6; i++) begin
            strobe(tbl[i].data, tbl[i].rw, s);
            if (tbl[i].rw) begin
                tick(500);
                ones = 0; bz = 0;
                for (int k = 0; k < 500; k++) begin
                    if (tx_log[s+k] === 1'b1) ones++;
                    if (busy_log[s+k] === 1'b1) bz++;
                end
                chk($sformatf("vec%0d write tx idle", i), 64'(ones), 64'd500);
                chk($sformatf("vec%0d write busy", i), 64'(bz), 64'd0);
            end else begin
                tick(REPLY + 10);
                check_reply(s, tbl[i].reply, $sformatf("vec%0d", i));
                check_busy(s, REPLY, $sformatf("vec%0d", i));
            end
        end
        chk("no overrun after table", 64'(overrun_o), 64'd0);

        // Two reads one cycle apart: second follows with no idle gap.
        strobe(16'h0001, 1'b0, s);
        tick();
        strobe(16'hA0F9, 1'b0, s2);
        tick(2*REPLY + 10);
        check_reply(s, 56'h4D_30_30_30_31_0D_0A, "pair first");
        check_reply(s + REPLY, 56'h4D_41_30_46_39_0D_0A, "pair second");
        check_busy(s, 2*REPLY, "pair");
        chk("pair overrun", 64'(overrun_o), 64'd0);

        // Three back-to-back reads: third is dropped.
        strobe(16'h1111, 1'b0, s);
        strobe(16'h2222, 1'b0, s2);
        strobe(16'h3333, 1'b0, s2);
        tick(2*REPLY + 3*CHRL);
        check_reply(s, 56'h4D_31_31_31_31_0D_0A, "triple first");
        check_reply(s + REPLY, 56'h4D_32_32_32_32_0D_0A, "triple second");
        check_busy(s, 2*REPLY, "triple");
        chk("triple overrun sticky", 64'(overrun_o), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("overrun cleared", 64'(overrun_o), 64'd0);
        tick(2);

        // Reset during bit 3 of char 2 ('E' bit3 = 0).
        strobe(16'hBEEF, 1'b0, s);
        wait_cyc(s + 2*CHRL + 4*CPB + 1);
        chk("mid tx before reset", 64'(tx), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid reset tx", 64'(tx), 64'd1);
        chk("mid reset busy", 64'(busy_o), 64'd0);
        tick(20);
        ones = 0;
        for (int k = 1; k <= 20; k++) if (tx_log[cyc-k] === 1'b1) ones++;
        chk("post reset idle", 64'(ones), 64'd20);
        strobe(16'h0000, 1'b0, s);
        tick(REPLY + 10);
        check_reply(s, 56'h4D_30_30_30_30_0D_0A, "after reset");
        check_busy(s, REPLY, "after reset");

        // Accept in the very cycle the active reply finishes.
        strobe(16'hC0DE, 1'b0, s);
        wait_cyc(s + REPLY - 1);
        strobe(16'h7B3D, 1'b0, s2);
        tick(REPLY + 10);
        chk("simul start", 64'(s2), 64'(s + REPLY));
        check_reply(s, 56'h4D_43_30_44_45_0D_0A, "simul first");
        check_reply(s + REPLY, 56'h4D_37_42_33_44_0D_0A, "simul second");
        check_busy(s, 2*REPLY, "simul");
        chk("simul overrun", 64'(overrun_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
